// File: rtl/alu_pipe_if.sv
// alu_pipe_if: valid/ready operand and result channels of alu_pipe.
// master = the side that issues operations and consumes results,
// slave  = the ALU itself.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with 8 opcodes and {V, C, N, Z} flags,
// valid/ready on both sides, one result register, latency 1, 1 op/cycle.
// Optional macro ALU_PIPE_SAT_EN: ADD/SUB saturate on signed overflow
// (V still reports the overflow, C unchanged, Z/N follow the saturated value).
module alu_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_LAND = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             c_f;
    logic             v_f;
    logic             z_f;
    logic             n_f;
    logic             accept;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Next result and flags from the current operands and opcode.
    always_comb begin
        sum  = {1'b0, bus.a} + {1'b0, bus.b};
        diff = {1'b0, bus.a} - {1'b0, bus.b};
        res  = '0;
        c_f  = 1'b0;
        v_f  = 1'b0;
        case (op_e'(bus.op))
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_NOT:  res = ~bus.a;
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c_f = sum[WIDTH];
                v_f = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                      (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c_f = diff[WIDTH];   // borrow: a < b unsigned
                v_f = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                      (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_LAND: res[0] = (|bus.a) & (|bus.b);
            OP_PASS: res = bus.a;
            default: res = '0;
        endcase
`ifdef ALU_PIPE_SAT_EN
        // Overflow direction always matches the sign of a for both ADD and SUB.
        if (v_f) begin
            res = bus.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        z_f = (res == '0);
        n_f = res[WIDTH-1];
    end

    // Result register: load on accept, drop valid on a transfer without reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= res;
            flags_q     <= {v_f, c_f, n_f, z_f};
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
